axi4_burst_mgr: RTL and testbench
=================================

// Module: axi4_burst_mgr
// PURPOSE
//  Parametrised AXI4 burst manager: accepts read/write commands on a valid/ready port and moves data between
//  AXI4 and local streams. Splits each command into INCR sub-bursts at MAX_BURST_LEN and 4 KiB boundaries.
//  Returns one merged status per command. Sits between the AXI-Lite control regs and the AXI4 fabric.
// PARAMETERS
//  AXI_ADDR_WIDTH  32  AXI4 address width
//  AXI_DATA_WIDTH  64  AXI4 data width (8..1024, power of 2)
//  AXI_ID_WIDTH    3   ID width; all beats carry AXI_ID
//  AXI_ID          0   constant ID driven on AW/AR
//  MAX_BURST_LEN   256 max beats per sub-burst (1..256)
//  CNT_WIDTH       16  width of command beat count
// PORTS
//  clk_i            in   1       clock
//  rst_i            in   1       synchronous reset, active-high
//  cmd_valid_i/cmd_ready_o  in/out 1  command handshake
//  cmd_write_i      in   1       1=write, 0=read
//  cmd_addr_i       in   AW      start byte address (low log2(BYTES) bits ignored)
//  cmd_beats_i      in   CNT     total beats
//  wr_data_i/wr_valid_i/wr_ready_o  in/in/out  DW/1/1  local write stream
//  rd_data_o/rd_valid_o/rd_ready_i  out/out/in DW/1/1  local read stream
//  sts_valid_o/sts_ready_i  out/in 1  status handshake
//  sts_resp_o       out  2       merged response for the command
//  busy_o           out  1       high while a command is in flight
//  m_aw_{id,addr,len,size,burst,valid}_o, m_aw_ready_i   AXI4 AW
//  m_w_{data,strb,last,valid}_o, m_w_ready_i            AXI4 W
//  m_b_{id,resp,valid}_i, m_b_ready_o                   AXI4 B
//  m_ar_{id,addr,len,size,burst,valid}_o, m_ar_ready_i   AXI4 AR
//  m_r_{id,data,resp,last,valid}_i, m_r_ready_o         AXI4 R
// BEHAVIOUR
//  Reset: every valid/ready output is 0, busy_o=0, sts_resp_o=0, address/len outputs are 0, FSM=IDLE.
//  Constants: size=log2(DW/8), burst=INCR(2'b01), strb all ones.
//  FSM: IDLE -> AR -> RDAT -> (AR | STS); IDLE -> AW -> WDAT -> BRSP -> (AW | STS); STS -> IDLE.
//  IDLE: cmd_ready_o=1. On accept, latch addr (aligned), remaining=beats, resp_acc=OKAY.
//    If beats==0, go directly to STS with OKAY; no AXI traffic.
//  Sub-burst length n = min(remaining, MAX_BURST_LEN, (4096-addr[11:0])>>log2(BYTES)); len=n-1.
//    Register n in AR/AW entry; AxVALID holds stable until ready; addr += n*BYTES, remaining -= n.
//  RDAT: m_r_ready_o = rd_ready_i; rd_valid_o = m_r_valid_i (pass-through, zero latency).
//    Leave on rlast. An rlast that arrives early or late is not checked; beat count is trusted.
//  WDAT: m_w_valid_o = wr_valid_i; wr_ready_o = m_w_ready_i; wlast on beat n.
//    W never starts before AW is accepted.
//  BRSP: b_ready=1. Leave on bvalid.
//  Resp merge: resp_acc = max(resp_acc, resp) over every R beat / B.
//    Priority DECERR(3) > SLVERR(2) > EXOKAY/OKAY. An error does not abort remaining sub-bursts.
//  STS: sts_valid_o=1 with resp_acc until sts_ready_i; next command not accepted before.
//  busy_o = (state != IDLE).
//  One command outstanding; at most one sub-burst in flight per direction.
//  Reset mid-operation returns to IDLE at once. AXI protocol recovery is the system's job (fabric reset together).
//  Address wrap at 2^AW is modulo, with no error.
// STRUCTURE
//  Package axi4_burst_mgr_pkg: burst/resp encodings, BYTES, ADDR_LSB=log2(BYTES), state enum.
//  Sub-module axi4_burst_len_calc (combinational n from addr/remaining/MAX_BURST_LEN).
//  All else in one always_ff FSM plus counters.
// TESTING
//  Write addr 0x1000, 4 beats, DW=64 -> one AW len=3, addr 0x1000; 4 W beats, wlast on 4th; sts OKAY.
//  Read addr 0x0FF0, 8 beats -> AR 0x0FF0 len=1, then AR 0x1000 len=5; 8 rd beats in order.
//  Write of 300 beats at 0x0, MAX_BURST_LEN=256 -> AW len=255 then AW len=43 at 0x800.
//  Read where 2nd of 3 sub-bursts returns SLVERR on one beat -> all sub-bursts issued; sts_resp_o=2.
//  cmd_beats_i=0 -> no AW/AR; sts_valid_o after 1 cycle, resp 0.
//  Backpressure: random rd_ready/wr_valid/AxREADY -> no data loss; AxVALID/addr stable until handshake.
//  rst_i pulsed during WDAT -> next cycle all valids 0, busy_o=0, cmd_ready_o=1.

Source files
------------

// File: rtl/axi4_burst_mgr_pkg.sv
// axi4_burst_mgr_pkg: shared encodings, FSM states and beat-size helpers for the burst manager
package axi4_burst_mgr_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_RDAT,
        ST_AW,
        ST_WDAT,
        ST_BRSP,
        ST_STS
    } state_t;

    function automatic int unsigned bytes_of(int unsigned dw);
        return dw / 8;
    endfunction

    function automatic int unsigned addr_lsb(int unsigned dw);
        return $clog2(dw / 8);
    endfunction

    // Higher encodings are the more severe errors, so merging is a plain max
    function automatic logic [1:0] resp_max(logic [1:0] a, logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi4_burst_len_calc.sv
// axi4_burst_len_calc: beats in the next sub-burst, limited by remaining beats, max burst and the 4 KiB page
module axi4_burst_len_calc
    import axi4_burst_mgr_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int MAX_BURST_LEN  = 256,
    parameter int CNT_WIDTH      = 16
) (
    input  logic [11:0]          page_off,
    input  logic [CNT_WIDTH-1:0] remaining,
    output logic [8:0]           n
);

    localparam int LSB = addr_lsb(AXI_DATA_WIDTH);
    localparam int W   = (CNT_WIDTH > 13) ? CNT_WIDTH : 13;

    logic [W-1:0] page_beats;
    logic [W-1:0] rem_w;
    logic [W-1:0] lim;

    assign page_beats = W'((13'd4096 - {1'b0, page_off}) >> LSB);
    assign rem_w      = W'(remaining);
    assign lim        = (rem_w < page_beats) ? rem_w : page_beats;
    assign n          = (lim < W'(MAX_BURST_LEN)) ? 9'(lim) : 9'(MAX_BURST_LEN);

endmodule

// File: rtl/axi4_burst_mgr.sv
// axi4_burst_mgr: splits read/write commands into INCR sub-bursts and streams data between AXI4 and local ports
module axi4_burst_mgr
    import axi4_burst_mgr_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_ID         = 0,
    parameter int MAX_BURST_LEN  = 256,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_write_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [CNT_WIDTH-1:0]        cmd_beats_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data_i,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    output logic [AXI_DATA_WIDTH-1:0]   rd_data_o,
    output logic                        rd_valid_o,
    input  logic                        rd_ready_i,
    output logic                        sts_valid_o,
    input  logic                        sts_ready_i,
    output logic [1:0]                  sts_resp_o,
    output logic                        busy_o,
    output logic [AXI_ID_WIDTH-1:0]     m_aw_id_o,
    output logic [AXI_ADDR_WIDTH-1:0]   m_aw_addr_o,
    output logic [7:0]                  m_aw_len_o,
    output logic [2:0]                  m_aw_size_o,
    output logic [1:0]                  m_aw_burst_o,
    output logic                        m_aw_valid_o,
    input  logic                        m_aw_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   m_w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] m_w_strb_o,
    output logic                        m_w_last_o,
    output logic                        m_w_valid_o,
    input  logic                        m_w_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]     m_b_id_i,
    input  logic [1:0]                  m_b_resp_i,
    input  logic                        m_b_valid_i,
    output logic                        m_b_ready_o,
    output logic [AXI_ID_WIDTH-1:0]     m_ar_id_o,
    output logic [AXI_ADDR_WIDTH-1:0]   m_ar_addr_o,
    output logic [7:0]                  m_ar_len_o,
    output logic [2:0]                  m_ar_size_o,
    output logic [1:0]                  m_ar_burst_o,
    output logic                        m_ar_valid_o,
    input  logic                        m_ar_ready_i,
    input  logic [AXI_ID_WIDTH-1:0]     m_r_id_i,
    input  logic [AXI_DATA_WIDTH-1:0]   m_r_data_i,
    input  logic [1:0]                  m_r_resp_i,
    input  logic                        m_r_last_i,
    input  logic                        m_r_valid_i,
    output logic                        m_r_ready_o
);

    localparam int LSB = addr_lsb(AXI_DATA_WIDTH);

    state_t                    state, state_nx;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]      remaining;
    logic [7:0]                len;
    logic [7:0]                wcnt;
    logic [1:0]                resp_acc;
    logic [AXI_ADDR_WIDTH-1:0] cmd_addr_al;
    logic [11:0]               calc_off;
    logic [CNT_WIDTH-1:0]      calc_rem;
    logic [8:0]                n_calc;
    logic [8:0]                n_cur;
    logic                      ax_fire, r_fire, w_fire, b_fire;
    logic                      unused_ids;

    // Beats always carry the single configured ID, so returned IDs are not inspected
    assign unused_ids = ^{m_b_id_i, m_r_id_i};

    assign cmd_addr_al = cmd_addr_i & ~AXI_ADDR_WIDTH'((1 << LSB) - 1);
    // In IDLE the first sub-burst is sized straight from the incoming command
    assign calc_off    = (state == ST_IDLE) ? cmd_addr_al[11:0] : addr[11:0];
    assign calc_rem    = (state == ST_IDLE) ? cmd_beats_i : remaining;
    assign n_cur       = {1'b0, len} + 9'd1;

    axi4_burst_len_calc #(
        .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_len (
        .page_off (calc_off),
        .remaining(calc_rem),
        .n        (n_calc)
    );

    assign ax_fire = (state == ST_AR && m_ar_ready_i) || (state == ST_AW && m_aw_ready_i);
    assign r_fire  = (state == ST_RDAT) && m_r_valid_i && rd_ready_i;
    assign w_fire  = (state == ST_WDAT) && wr_valid_i && m_w_ready_i;
    assign b_fire  = (state == ST_BRSP) && m_b_valid_i;

    assign cmd_ready_o  = (state == ST_IDLE) && !rst_i;
    assign busy_o       = (state != ST_IDLE);
    assign sts_valid_o  = (state == ST_STS);
    assign sts_resp_o   = resp_acc;
    assign m_aw_id_o    = AXI_ID_WIDTH'(AXI_ID);
    assign m_aw_addr_o  = addr;
    assign m_aw_len_o   = len;
    assign m_aw_size_o  = 3'(LSB);
    assign m_aw_burst_o = BURST_INCR;
    assign m_aw_valid_o = (state == ST_AW);
    assign m_ar_id_o    = AXI_ID_WIDTH'(AXI_ID);
    assign m_ar_addr_o  = addr;
    assign m_ar_len_o   = len;
    assign m_ar_size_o  = 3'(LSB);
    assign m_ar_burst_o = BURST_INCR;
    assign m_ar_valid_o = (state == ST_AR);
    assign m_w_data_o   = wr_data_i;
    assign m_w_strb_o   = '1;
    assign m_w_last_o   = (state == ST_WDAT) && (wcnt == len);
    assign m_w_valid_o  = (state == ST_WDAT) && wr_valid_i;
    assign wr_ready_o   = (state == ST_WDAT) && m_w_ready_i;
    assign m_b_ready_o  = (state == ST_BRSP);
    assign rd_data_o    = m_r_data_i;
    assign rd_valid_o   = (state == ST_RDAT) && m_r_valid_i;
    assign m_r_ready_o  = (state == ST_RDAT) && rd_ready_i;

    // Next-state selection; data phases end on rlast/B and loop back while beats remain
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (cmd_valid_i) state_nx = (cmd_beats_i == '0) ? ST_STS : (cmd_write_i ? ST_AW : ST_AR);
            ST_AR:   if (m_ar_ready_i) state_nx = ST_RDAT;
            ST_RDAT: if (r_fire && m_r_last_i) state_nx = (remaining == '0) ? ST_STS : ST_AR;
            ST_AW:   if (m_aw_ready_i) state_nx = ST_WDAT;
            ST_WDAT: if (w_fire && wcnt == len) state_nx = ST_BRSP;
            ST_BRSP: if (m_b_valid_i) state_nx = (remaining == '0) ? ST_STS : ST_AW;
            ST_STS:  if (sts_ready_i) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register plus address/beat bookkeeping and response merging
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            len       <= '0;
            wcnt      <= '0;
            resp_acc  <= RESP_OKAY;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && cmd_valid_i) begin
                addr      <= cmd_addr_al;
                remaining <= cmd_beats_i;
                resp_acc  <= RESP_OKAY;
            end
            if ((state_nx == ST_AR || state_nx == ST_AW) && state_nx != state)
                len <= 8'(n_calc - 9'd1);
            if (ax_fire) begin
                addr      <= addr + (AXI_ADDR_WIDTH'(n_cur) << LSB);
                remaining <= remaining - CNT_WIDTH'(n_cur);
                wcnt      <= '0;
            end
            if (w_fire)
                wcnt <= wcnt + 8'd1;
            if (r_fire)
                resp_acc <= resp_max(resp_acc, m_r_resp_i);
            if (b_fire)
                resp_acc <= resp_max(resp_acc, m_b_resp_i);
        end
    end

endmodule

// File: tb/tb_axi4_burst_mgr.sv
// tb_axi4_burst_mgr: table-driven and randomized checks of the burst manager against a page/burst split model
module tb_axi4_burst_mgr;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        int          beats;
        int          esub;
        int          ebeat;
        logic [1:0]  eresp;
        int          nb;
        logic [31:0] a1;
        int          len0;
        int          len1;
        logic [1:0]  resp;
    } vec_t;

    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [31:0] cmd_addr = 0;
    logic [15:0] cmd_beats = 0;
    logic [63:0] wr_data = 0, rd_data;
    logic        wr_valid = 0, wr_ready, rd_valid, rd_ready = 0;
    logic        sts_valid, sts_ready = 0, busy;
    logic [1:0]  sts_resp;
    logic [2:0]  aw_id, ar_id, aw_size, ar_size;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len, w_strb;
    logic [1:0]  aw_burst, ar_burst;
    logic        aw_valid, aw_ready = 0, ar_valid, ar_ready = 0;
    logic [63:0] w_data;
    logic        w_last, w_valid, w_ready = 0;
    logic [2:0]  b_id = 0, r_id = 0;
    logic [1:0]  b_resp = 0, r_resp = 0;
    logic        b_valid = 0, b_ready;
    logic [63:0] r_data = 0;
    logic        r_last = 0, r_valid = 0, r_ready;

    int          total = 0, bad = 0, cyc = 0;
    burst_t      exp_q[$], act_q[$], act_log[$];
    bit          is_wr, done, cmd_f, r_f, b_f, ax_wait;
    logic [31:0] base, ax_prev_a;
    logic [7:0]  ax_prev_l;
    logic [1:0]  exp_resp, eresp;
    int          beat, sub, rk, wk, b_pend, esub, ebeat, sts_first, acc_cyc;
    vec_t        vt[9];

    always #5 clk = ~clk;

    axi4_burst_mgr dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_beats_i(cmd_beats),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
        .sts_valid_o(sts_valid), .sts_ready_i(sts_ready), .sts_resp_o(sts_resp), .busy_o(busy),
        .m_aw_id_o(aw_id), .m_aw_addr_o(aw_addr), .m_aw_len_o(aw_len), .m_aw_size_o(aw_size),
        .m_aw_burst_o(aw_burst), .m_aw_valid_o(aw_valid), .m_aw_ready_i(aw_ready),
        .m_w_data_o(w_data), .m_w_strb_o(w_strb), .m_w_last_o(w_last), .m_w_valid_o(w_valid),
        .m_w_ready_i(w_ready),
        .m_b_id_i(b_id), .m_b_resp_i(b_resp), .m_b_valid_i(b_valid), .m_b_ready_o(b_ready),
        .m_ar_id_o(ar_id), .m_ar_addr_o(ar_addr), .m_ar_len_o(ar_len), .m_ar_size_o(ar_size),
        .m_ar_burst_o(ar_burst), .m_ar_valid_o(ar_valid), .m_ar_ready_i(ar_ready),
        .m_r_id_i(r_id), .m_r_data_i(r_data), .m_r_resp_i(r_resp), .m_r_last_i(r_last),
        .m_r_valid_i(r_valid), .m_r_ready_o(r_ready)
    );

    function automatic logic [63:0] pat(logic [31:0] a);
        return {a, ~a ^ 32'h1357_9BDF};
    endfunction

    function automatic logic [63:0] wpat(int k);
        return (64'(k) * 64'h9E37_79B9_7F4A_7C15) ^ 64'hFEED;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        bad++;
        $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Reference split: each sub-burst is the largest piece that fits the burst cap and stays inside its 4 KiB page
    task automatic build_exp(logic [31:0] a, int beats);
        burst_t b;
        int     rem = beats, page, n;
        exp_q.delete();
        while (rem > 0) begin
            page = (4096 - int'(a % 4096)) / 8;
            n = rem;
            if (n > 256) n = 256;
            if (n > page) n = page;
            b.addr = a;
            b.len  = n - 1;
            exp_q.push_back(b);
            a   = a + 32'(n * 8);
            rem = rem - n;
        end
    endtask

    // One clock: drive inputs at negedge, sample 1 time unit before posedge, then wait for next negedge
    task automatic tick();
        logic        axv, axr;
        logic [31:0] axa;
        logic [7:0]  axl;
        logic [2:0]  axs, axi;
        logic [1:0]  axb;
        burst_t      bt;
        if (cmd_f) cmd_valid = 0;
        if (r_f) r_valid = 0;
        if (b_f) b_valid = 0;
        cmd_f = 0; r_f = 0; b_f = 0;
        rd_ready  = $urandom_range(0, 3) != 0;
        sts_ready = $urandom_range(0, 2) != 0;
        ar_ready  = $urandom_range(0, 2) != 0;
        aw_ready  = $urandom_range(0, 2) != 0;
        w_ready   = $urandom_range(0, 3) != 0;
        wr_valid  = $urandom_range(0, 3) != 0;
        wr_data   = wpat(wk);
        if (!r_valid && !is_wr && act_q.size() > 0 && $urandom_range(0, 3) != 0) r_valid = 1;
        if (r_valid && act_q.size() > 0) begin
            r_data = pat(act_q[0].addr + 32'(8 * beat));
            r_last = (beat == act_q[0].len);
            r_resp = (sub == esub && beat == ebeat) ? eresp : 2'b00;
        end
        if (!b_valid && b_pend > 0 && $urandom_range(0, 1) != 0) begin
            b_valid = 1;
            b_resp  = (sub == esub) ? eresp : 2'b00;
        end
        #4;
        cyc++;
        axv = is_wr ? aw_valid : ar_valid;
        axr = is_wr ? aw_ready : ar_ready;
        axa = is_wr ? aw_addr : ar_addr;
        axl = is_wr ? aw_len : ar_len;
        axs = is_wr ? aw_size : ar_size;
        axb = is_wr ? aw_burst : ar_burst;
        axi = is_wr ? aw_id : ar_id;
        if (ax_wait) begin
            chk("ax_hold_valid", axv, 1);
            chk("ax_hold_addr", axa, ax_prev_a);
            chk("ax_hold_len", axl, ax_prev_l);
        end
        ax_wait   = axv && !axr;
        ax_prev_a = axa;
        ax_prev_l = axl;
        if (w_valid && act_q.size() == 0) fail("w_before_aw", w_valid, 0);
        if ((wr_valid && wr_ready) || (w_valid && w_ready)) chk("w_pass", w_valid && w_ready, wr_valid && wr_ready);
        if (w_valid && w_ready && act_q.size() > 0) begin
            chk("w_data", w_data, wpat(wk));
            chk("w_last", w_last, beat == act_q[0].len);
            chk("w_strb", w_strb, 8'hFF);
            wk++;
            if (beat == act_q[0].len) begin
                beat = 0;
                void'(act_q.pop_front());
                b_pend++;
            end else beat++;
        end
        if ((r_valid && r_ready) || (rd_valid && rd_ready)) chk("rd_pass", rd_valid && rd_ready, r_valid && r_ready);
        if (r_valid && r_ready) begin
            chk("rd_data", rd_data, pat(base + 32'(8 * rk)));
            rk++;
            r_f = 1;
            if (r_last) begin
                beat = 0;
                sub++;
                if (act_q.size() > 0) void'(act_q.pop_front());
            end else beat++;
        end
        if (b_valid && b_ready) begin
            b_f = 1;
            b_pend--;
            sub++;
        end
        if (axv && axr) begin
            bt.addr = axa;
            bt.len  = int'(axl);
            act_log.push_back(bt);
            act_q.push_back(bt);
            if (exp_q.size() == 0) fail("ax_extra", axa, 0);
            else begin
                bt = exp_q.pop_front();
                chk("ax_addr", axa, bt.addr);
                chk("ax_len", axl, bt.len);
            end
            chk("ax_size", axs, 3);
            chk("ax_burst", axb, 1);
            chk("ax_id", axi, 0);
        end
        if (sts_valid && sts_first < 0) sts_first = cyc;
        if (sts_valid && sts_ready) begin
            chk("sts_resp", sts_resp, exp_resp);
            done = 1;
        end
        if (cmd_valid && cmd_ready) begin
            cmd_f   = 1;
            acc_cyc = cyc;
        end
        @(negedge clk);
    endtask

    task automatic start_cmd(vec_t v);
        is_wr     = v.wr;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_beats = 16'(v.beats);
        cmd_valid = 1;
        base      = v.addr & ~32'h7;
        build_exp(base, v.beats);
        exp_resp  = (v.esub >= 0 && v.esub < exp_q.size()) ? v.eresp : 2'b00;
        esub = v.esub; ebeat = v.ebeat; eresp = v.eresp;
        act_q.delete(); act_log.delete();
        beat = 0; sub = 0; rk = 0; wk = 0; b_pend = 0;
        done = 0; ax_wait = 0; sts_first = -1; acc_cyc = -1;
    endtask

    task automatic run_cmd(vec_t v);
        start_cmd(v);
        for (int i = 0; i < 20000 && !done; i++) tick();
        if (!done) fail("timeout", cyc, 0);
        chk("ax_left", exp_q.size(), 0);
        chk("beats", is_wr ? wk : rk, v.beats);
        if (v.beats == 0) chk("zero_sts_lat", sts_first - acc_cyc, 1);
    endtask

    initial begin
        vec_t rv;
        vt[0] = '{1'b1, 32'h0000_1000,   4, -1, 0, 2'd0, 1, 32'h0,    3,   0, 2'd0};
        vt[1] = '{1'b0, 32'h0000_0FF0,   8, -1, 0, 2'd0, 2, 32'h1000, 1,   5, 2'd0};
        vt[2] = '{1'b1, 32'h0000_0000, 300, -1, 0, 2'd0, 2, 32'h800,  255, 43, 2'd0};
        vt[3] = '{1'b0, 32'h0000_0FF0, 300,  1, 5, 2'd2, 3, 32'h1000, 1,  255, 2'd2};
        vt[4] = '{1'b1, 32'h0000_2000,   0, -1, 0, 2'd0, 0, 32'h0,    0,   0, 2'd0};
        vt[5] = '{1'b1, 32'h0000_1FF8,   3,  0, 0, 2'd3, 2, 32'h2000, 0,   1, 2'd3};
        vt[6] = '{1'b0, 32'hFFFF_FFF8,   3, -1, 0, 2'd0, 2, 32'h0,    0,   1, 2'd0};
        vt[7] = '{1'b0, 32'h0000_1003,   2,  0, 1, 2'd1, 1, 32'h0,    1,   0, 2'd1};
        vt[8] = '{1'b0, 32'h0000_0000,   1,  0, 0, 2'd3, 1, 32'h0,    0,   0, 2'd3};
        repeat (2) @(negedge clk);
        #4;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valids", {aw_valid, w_valid, ar_valid, sts_valid, rd_valid}, 0);
        chk("rst_readies", {wr_ready, b_ready, r_ready}, 0);
        chk("rst_addr", {aw_addr, ar_addr}, 0);
        chk("rst_len", {aw_len, ar_len}, 0);
        chk("rst_sts_resp", sts_resp, 0);
        @(negedge clk);
        rst = 0;
        foreach (vt[k]) begin
            run_cmd(vt[k]);
            chk("tbl_nb", act_log.size(), vt[k].nb);
            if (vt[k].nb >= 1 && act_log.size() >= 1) begin
                chk("tbl_a0", act_log[0].addr, vt[k].addr & ~32'h7);
                chk("tbl_len0", act_log[0].len, vt[k].len0);
            end
            if (vt[k].nb >= 2 && act_log.size() >= 2) begin
                chk("tbl_a1", act_log[1].addr, vt[k].a1);
                chk("tbl_len1", act_log[1].len, vt[k].len1);
            end
            chk("tbl_resp", exp_resp, vt[k].resp);
        end
        for (int k = 0; k < 15; k++) begin
            rv.wr    = $urandom_range(0, 1) != 0;
            rv.addr  = $urandom;
            if ($urandom_range(0, 1) != 0) rv.addr[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
            rv.beats = $urandom_range(0, 400);
            rv.esub  = int'($urandom_range(0, 4)) - 1;
            rv.ebeat = 0;
            rv.eresp = 2'($urandom_range(0, 3));
            run_cmd(rv);
        end
        rv = vt[0];
        rv.addr  = 32'h4000;
        rv.beats = 64;
        start_cmd(rv);
        for (int i = 0; i < 2000 && wk < 3; i++) tick();
        if (wk < 3) fail("rst_reach_wdat", wk, 3);
        rst = 1; wr_valid = 1; cmd_valid = 0; r_valid = 0; b_valid = 0;
        cmd_f = 0; r_f = 0; b_f = 0;
        @(negedge clk);
        rst = 0;
        #4;
        chk("midrst_valids", {aw_valid, w_valid, ar_valid, sts_valid}, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        run_cmd(vt[1]);
        chk("post_rst_nb", act_log.size(), 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
